// File: rtl/wb_master_arb_if.sv
// Purpose: one Wishbone master-to-slave link (request fields plus read data and ack).
// Latency: pure wiring, no storage.
// Backpressure: stb is held by the master until ack; the slave stalls by withholding ack.
// Signals: wdat/adr/sel/we/stb flow master->slave; rdat/ack flow slave->master.
interface wb_master_arb_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = 4
);
    logic [DW-1:0] wdat;
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic          we;
    logic          stb;
    logic [DW-1:0] rdat;
    logic          ack;

    modport master (output wdat, adr, sel, we, stb, input rdat, ack);
    modport slave  (input wdat, adr, sel, we, stb, output rdat, ack);
endinterface

// File: rtl/wb_master_arb.sv
// Purpose: round-robin arbiter giving two Wishbone masters (m0 CPU, m1 DMA/debug) one shared
//          slave port, with a watchdog that force-terminates transfers no slave acknowledges.
// Latency: grant one cycle after stb is seen in IDLE; ack/read data pass through combinationally.
// Backpressure: the losing master is stalled (ack=0) until the winner finishes; one IDLE cycle
//          separates consecutive grants.
// Ports: clk_i/rst_i (sync, active-high); m0/m1 master links (slave modport); s shared bus
//        (master modport); gnt_o one-hot grant; last_o last served master; timeout_o one-cycle
//        pulse on forced termination; err_src_o sticky per-master timeout flags.
module wb_master_arb #(
    parameter int              DW       = 32,
    parameter int              AW       = 32,
    parameter int              SW       = 4,
    parameter int              TIMEOUT  = 255,
    parameter int              CW       = 8,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_master_arb_if.slave     m0,
    wb_master_arb_if.slave     m1,
    wb_master_arb_if.master    s,
    output logic [1:0]         gnt_o,
    output logic               last_o,
    output logic               timeout_o,
    output logic [1:0]         err_src_o
);

    typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;      // granted master index, valid outside IDLE
    logic          last_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic [1:0]    err_d;
    logic          gstb;

    // The mux select is the registered grant, so the other master's stb can never
    // steer the shared bus mid-transfer.
    assign gstb = gnt_q ? m1.stb : m0.stb;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_o;
        wdog_d    = wdog_q;
        err_d     = err_src_o;
        gnt_o     = 2'b00;
        timeout_o = 1'b0;
        s.wdat    = '0;
        s.adr     = '0;
        s.sel     = '0;
        s.we      = 1'b0;
        s.stb     = 1'b0;
        m0.ack    = 1'b0;
        m0.rdat   = '0;
        m1.ack    = 1'b0;
        m1.rdat   = '0;

        if (state_q != IDLE) begin
            gnt_o = gnt_q ? 2'b10 : 2'b01;
        end

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (m0.stb || m1.stb) begin
                    state_d = BUSY;
                    // On a tie the master not served last wins.
                    gnt_d = (m0.stb && m1.stb) ? ~last_o : m1.stb;
                end
            end
            BUSY: begin
                s.wdat = gnt_q ? m1.wdat : m0.wdat;
                s.adr  = gnt_q ? m1.adr  : m0.adr;
                s.sel  = gnt_q ? m1.sel  : m0.sel;
                s.we   = gnt_q ? m1.we   : m0.we;
                s.stb  = gstb;
                if (gnt_q) begin
                    m1.ack  = s.ack;
                    m1.rdat = s.rdat;
                end else begin
                    m0.ack  = s.ack;
                    m0.rdat = s.rdat;
                end
                wdog_d = wdog_q + 1'b1;
                // Ack outranks both abort and watchdog expiry.
                if (s.ack) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end else if (!gstb) begin
                    state_d = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    state_d = TERM;
                end
            end
            TERM: begin
                // Bus request already withdrawn; the master gets an error-data ack.
                timeout_o = 1'b1;
                if (gnt_q) begin
                    m1.ack  = 1'b1;
                    m1.rdat = ERR_DATA;
                end else begin
                    m0.ack  = 1'b1;
                    m0.rdat = ERR_DATA;
                end
                wdog_d        = '0;
                err_d[gnt_q]  = 1'b1;
                last_d        = gnt_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_o    <= 1'b1;
            wdog_q    <= '0;
            err_src_o <= 2'b00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_o    <= last_d;
            wdog_q    <= wdog_d;
            err_src_o <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_master_arb.sv
// Purpose: self-checking bench for wb_master_arb: directed scenarios with literal expectations
//          followed by randomized masters/slave checked every cycle against a transaction model.
module tb_wb_master_arb;

    localparam int          TMO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_master_arb_if m0_bus ();
    wb_master_arb_if m1_bus ();
    wb_master_arb_if s_bus ();

    logic        stb_d[2];
    logic        we_d[2];
    logic [3:0]  sel_d[2];
    logic [31:0] adr_d[2];
    logic [31:0] wdat_d[2];
    logic        s_ack;
    logic [31:0] s_rdat;

    logic [1:0]  gnt;
    logic        last;
    logic        tmo;
    logic [1:0]  err;

    assign m0_bus.stb = stb_d[0];  assign m1_bus.stb = stb_d[1];
    assign m0_bus.we  = we_d[0];   assign m1_bus.we  = we_d[1];
    assign m0_bus.sel = sel_d[0];  assign m1_bus.sel = sel_d[1];
    assign m0_bus.adr = adr_d[0];  assign m1_bus.adr = adr_d[1];
    assign m0_bus.wdat = wdat_d[0]; assign m1_bus.wdat = wdat_d[1];
    assign s_bus.ack  = s_ack;
    assign s_bus.rdat = s_rdat;

    wb_master_arb #(.TIMEOUT(TMO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .s         (s_bus),
        .gnt_o     (gnt),
        .last_o    (last),
        .timeout_o (tmo),
        .err_src_o (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // own: master holding the bus (-1 none); age: BUSY cycles spent on this grant;
    // in_term: the watchdog has fired and the error ack is being returned this cycle.
    int         own = -1;
    int         age = 0;
    bit         in_term = 1'b0;
    logic       mlast = 1'b1;
    logic [1:0] merr = 2'b00;
    bit         model_ok = 1'b0;

    always @(negedge clk) begin : mdl
        logic [1:0]  e_gnt;
        logic [71:0] e_s;
        logic [32:0] e_m[2];
        logic        e_tmo;
        e_gnt = 2'b00; e_s = '0; e_m[0] = '0; e_m[1] = '0; e_tmo = 1'b0;
        if (own >= 0) begin
            e_gnt = (own == 1) ? 2'b10 : 2'b01;
            if (in_term) begin
                e_m[own] = {1'b1, ERR};
                e_tmo    = 1'b1;
            end else begin
                e_s      = {2'b00, stb_d[own], we_d[own], sel_d[own], adr_d[own], wdat_d[own]};
                e_m[own] = {s_ack, s_rdat};
            end
        end
        if (model_ok) begin
            chk("m_gnt", 72'(gnt), 72'(e_gnt));
            chk("m_sbus", {2'b00, s_bus.stb, s_bus.we, s_bus.sel, s_bus.adr, s_bus.wdat}, e_s);
            chk("m_m0", 72'({m0_bus.ack, m0_bus.rdat}), 72'(e_m[0]));
            chk("m_m1", 72'({m1_bus.ack, m1_bus.rdat}), 72'(e_m[1]));
            chk("m_tmo", 72'(tmo), 72'(e_tmo));
            chk("m_last", 72'(last), 72'(mlast));
            chk("m_err", 72'(err), 72'(merr));
        end
        // advance to the state that the coming clock edge produces
        if (rst) begin
            own = -1; in_term = 1'b0; age = 0; mlast = 1'b1; merr = 2'b00;
        end else if (own < 0) begin
            if (stb_d[0] || stb_d[1]) begin
                if (stb_d[0] && stb_d[1]) own = mlast ? 0 : 1;
                else                      own = stb_d[0] ? 0 : 1;
                age = 0;
                in_term = 1'b0;
            end
        end else if (in_term) begin
            merr[own] = 1'b1;
            mlast = own[0];
            own = -1;
            in_term = 1'b0;
        end else if (s_ack) begin
            mlast = own[0];
            own = -1;
        end else if (!stb_d[own]) begin
            own = -1;
        end else begin
            age++;
            if (age == TMO) in_term = 1'b1;
        end
        if (rst) model_ok = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_req(input int i);
        stb_d[i]  = 1'b1;
        adr_d[i]  = {(($urandom % 6) == 0) ? 4'hF : 4'h0, 28'($urandom)};
        wdat_d[i] = $urandom;
        sel_d[i]  = 4'($urandom);
        we_d[i]   = 1'($urandom);
    endtask

    initial begin : stim
        int n0, n1, viol, nack, term_at, tmo_cnt, idx;
        bit seen;
        logic saw[2];
        for (int i = 0; i < 2; i++) begin
            stb_d[i] = 1'b0; we_d[i] = 1'b0; sel_d[i] = 4'h0; adr_d[i] = '0; wdat_d[i] = '0;
            saw[i] = 1'b0;
        end
        s_ack = 1'b0; s_rdat = '0;

        // reset
        tick(); tick(); rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 72'(gnt), 72'd0);
        chk("rst_last", 72'(last), 72'd1);
        chk("rst_err", 72'(err), 72'd0);
        chk("rst_sstb", 72'(s_bus.stb), 72'd0);

        // single m0 read, acked on 3rd BUSY cycle
        tick(); stb_d[0] = 1'b1; adr_d[0] = 32'h0000_0010; sel_d[0] = 4'hF;
        @(negedge clk); chk("rd_pre_gnt", 72'(gnt), 72'd0);
        tick(); @(negedge clk);
        chk("rd_gnt", 72'(gnt), 72'd1);
        chk("rd_sadr", 72'(s_bus.adr), 72'h10);
        tick();
        tick(); s_ack = 1'b1; s_rdat = 32'h1234_5678;
        @(negedge clk);
        chk("rd_ack", 72'(m0_bus.ack), 72'd1);
        chk("rd_dat", 72'(m0_bus.rdat), 72'h1234_5678);
        tick(); s_ack = 1'b0; stb_d[0] = 1'b0;
        @(negedge clk);
        chk("rd_idle", 72'(gnt), 72'd0);
        chk("rd_last", 72'(last), 72'd0);

        // tie after reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; stb_d[0] = 1'b1; stb_d[1] = 1'b1;
        tick(); s_ack = 1'b1;
        @(negedge clk);
        chk("tie_first", 72'(gnt), 72'd1);
        chk("tie_m1_noack", 72'(m1_bus.ack), 72'd0);
        tick(); s_ack = 1'b0; stb_d[0] = 1'b0;
        @(negedge clk);
        chk("tie_gap", 72'(gnt), 72'd0);
        chk("tie_last0", 72'(last), 72'd0);
        tick(); s_ack = 1'b1;
        @(negedge clk); chk("tie_second", 72'(gnt), 72'd2);
        tick(); s_ack = 1'b0; stb_d[1] = 1'b0;
        @(negedge clk); chk("tie_last1", 72'(last), 72'd1);

        // round robin under continuous load, slave acks on first BUSY cycle
        tick(); stb_d[0] = 1'b1; stb_d[1] = 1'b1;
        n0 = 0; n1 = 0; viol = 0; nack = 0;
        for (int c = 0; c < 40 && nack < 10; c++) begin
            tick(); s_ack = s_bus.stb;
            @(negedge clk);
            if (gnt == 2'b01 && m1_bus.ack) viol++;
            if (gnt == 2'b10 && m0_bus.ack) viol++;
            if (m0_bus.ack || m1_bus.ack) begin
                idx = m1_bus.ack ? 1 : 0;
                chk("rr_order", 72'(idx), 72'(nack % 2));
                if (idx == 0) n0++; else n1++;
                nack++;
            end
        end
        chk("rr_n0", 72'(n0), 72'd5);
        chk("rr_n1", 72'(n1), 72'd5);
        chk("rr_iso", 72'(viol), 72'd0);
        tick(); s_ack = 1'b0; stb_d[0] = 1'b0; stb_d[1] = 1'b0;

        // timeout: m1 write to an unmapped address, never acked
        stb_d[1] = 1'b1; we_d[1] = 1'b1; adr_d[1] = 32'hF000_0040; wdat_d[1] = 32'hCAFE_0001;
        term_at = 0; tmo_cnt = 0; seen = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (seen) stb_d[1] = 1'b0;
            @(negedge clk);
            if (tmo) begin
                if (term_at == 0) term_at = c;
                tmo_cnt++;
                chk("to_ack", 72'(m1_bus.ack), 72'd1);
                chk("to_dat", 72'(m1_bus.rdat), 72'(ERR));
                chk("to_sstb", 72'(s_bus.stb), 72'd0);
                seen = 1'b1;
            end
        end
        chk("to_cycle", 72'(term_at), 72'(TMO + 1));
        chk("to_pulses", 72'(tmo_cnt), 72'd1);
        chk("to_err", 72'(err), 72'd2);
        tick(); stb_d[0] = 1'b1; we_d[0] = 1'b0; adr_d[0] = 32'h20;
        tick(); s_ack = 1'b1;
        tick(); s_ack = 1'b0; stb_d[0] = 1'b0;
        @(negedge clk);
        chk("to_err_sticky", 72'(err), 72'd2);
        chk("to_last", 72'(last), 72'd0);

        // abort: m0 drops stb on 2nd BUSY cycle
        tick(); stb_d[0] = 1'b1;
        tick();
        tick(); stb_d[0] = 1'b0;
        @(negedge clk); chk("ab_noack", 72'(m0_bus.ack), 72'd0);
        tick(); @(negedge clk);
        chk("ab_idle", 72'(gnt), 72'd0);
        chk("ab_last", 72'(last), 72'd0);
        chk("ab_tmo", 72'(tmo), 72'd0);

        // reset mid-transfer
        tick(); stb_d[1] = 1'b1; we_d[1] = 1'b0; adr_d[1] = 32'h30;
        tick(); @(negedge clk); chk("mr_busy", 72'(gnt), 72'd2);
        tick(); rst = 1'b1;
        tick(); @(negedge clk);
        chk("mr_gnt", 72'(gnt), 72'd0);
        chk("mr_sstb", 72'(s_bus.stb), 72'd0);
        chk("mr_err", 72'(err), 72'd0);
        chk("mr_last", 72'(last), 72'd1);
        tick(); rst = 1'b0;
        tick(); @(negedge clk); chk("mr_rearb", 72'(gnt), 72'd2);
        tick(); stb_d[1] = 1'b0;
        @(negedge clk);

        // randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (stb_d[i]) begin
                    if (saw[i]) begin
                        if ($urandom % 2 == 0) new_req(i); else stb_d[i] = 1'b0;
                    end else if ($urandom % 50 == 0) begin
                        stb_d[i] = 1'b0;
                    end
                end else if ($urandom % 3 == 0) begin
                    new_req(i);
                end
            end
            rst = (($urandom % 300) == 0);
            #1;
            s_rdat = $urandom;
            if (s_bus.stb && s_bus.adr[31:28] != 4'hF) s_ack = (($urandom % 3) == 0);
            else if (gnt == 2'b00 || tmo)            s_ack = (($urandom % 20) == 0);
            else                                     s_ack = 1'b0;
            @(negedge clk);
            saw[0] = m0_bus.ack;
            saw[1] = m1_bus.ack;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
